// File: rtl/spu_issue_pkg.sv
// rtl/spu_issue_pkg.sv - shared types and constants for the SPU dual-issue stage
package spu_issue_pkg;

  localparam int SPU_NUM_REGS         = 128;
  localparam int REG_ADDR_WIDTH       = 7;
  localparam int LAT_WIDTH            = 3;
  localparam int UNIT_ID_SIZE         = 3;
  localparam int INTERNAL_OPCODE_SIZE = 8;
  localparam int NUM_SRC_PORTS        = 5;

  localparam logic PIPE_EVEN = 1'b0;
  localparam logic PIPE_ODD  = 1'b1;

  localparam logic [UNIT_ID_SIZE-1:0] UNIT_FX1    = 3'd0;
  localparam logic [UNIT_ID_SIZE-1:0] UNIT_FX2    = 3'd1;
  localparam logic [UNIT_ID_SIZE-1:0] UNIT_BYTE   = 3'd2;
  localparam logic [UNIT_ID_SIZE-1:0] UNIT_PERM   = 3'd3;
  localparam logic [UNIT_ID_SIZE-1:0] UNIT_LS     = 3'd4;
  localparam logic [UNIT_ID_SIZE-1:0] UNIT_SP_FP  = 3'd5;
  localparam logic [UNIT_ID_SIZE-1:0] UNIT_SP_INT = 3'd6;

  localparam logic [LAT_WIDTH-1:0] LAT_FX1    = 3'd2;
  localparam logic [LAT_WIDTH-1:0] LAT_BYTE   = 3'd3;
  localparam logic [LAT_WIDTH-1:0] LAT_FX2    = 3'd3;
  localparam logic [LAT_WIDTH-1:0] LAT_PERM   = 3'd3;
  localparam logic [LAT_WIDTH-1:0] LAT_LS     = 3'd6;
  localparam logic [LAT_WIDTH-1:0] LAT_SP_FP  = 3'd6;
  localparam logic [LAT_WIDTH-1:0] LAT_SP_INT = 3'd7;

  typedef struct packed {
    logic                            pipe;
    logic [UNIT_ID_SIZE-1:0]         unit_id;
    logic [INTERNAL_OPCODE_SIZE-1:0] opcode;
    logic [REG_ADDR_WIDTH-1:0]       ra;
    logic [REG_ADDR_WIDTH-1:0]       rb;
    logic [REG_ADDR_WIDTH-1:0]       rc;
    logic [REG_ADDR_WIDTH-1:0]       rt;
    logic                            uses_ra;
    logic                            uses_rb;
    logic                            uses_rc;
    logic                            wr_en;
    logic [6:0]                      imm7;
    logic [9:0]                      imm10;
    logic [LAT_WIDTH-1:0]            lat;
  } decoded_inst_t;

  typedef struct packed {
    logic [UNIT_ID_SIZE-1:0]         unit_id;
    logic [INTERNAL_OPCODE_SIZE-1:0] opcode;
    logic [REG_ADDR_WIDTH-1:0]       ra;
    logic [REG_ADDR_WIDTH-1:0]       rb;
    logic [REG_ADDR_WIDTH-1:0]       rc;
    logic [REG_ADDR_WIDTH-1:0]       rt;
    logic [6:0]                      imm7;
    logic [9:0]                      imm10;
    logic                            wr_en;
  } issue_fields_t;

  // Strip the hazard-tracking fields, keeping what the datapath consumes.
  function automatic issue_fields_t to_issue(input decoded_inst_t d);
    issue_fields_t f;
    f.unit_id = d.unit_id;
    f.opcode  = d.opcode;
    f.ra      = d.ra;
    f.rb      = d.rb;
    f.rc      = d.rc;
    f.rt      = d.rt;
    f.imm7    = d.imm7;
    f.imm10   = d.imm10;
    f.wr_en   = d.wr_en;
    return f;
  endfunction

endpackage

// File: rtl/spu_scoreboard.sv
// rtl/spu_scoreboard.sv - per-register result latency counters
module spu_scoreboard
  import spu_issue_pkg::*;
#(
  parameter int NUM_REGS = SPU_NUM_REGS
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [1:0]                                       set_en,
  input  logic [1:0][REG_ADDR_WIDTH-1:0]                   set_addr,
  input  logic [1:0][LAT_WIDTH-1:0]                        set_lat,
  input  logic [NUM_SRC_PORTS-1:0][REG_ADDR_WIDTH-1:0]     src_addr,
  output logic [NUM_SRC_PORTS-1:0]                         src_ready,
  input  logic [1:0][REG_ADDR_WIDTH-1:0]                   rt_addr,
  output logic [1:0][LAT_WIDTH-1:0]                        rt_count
);

  logic [LAT_WIDTH-1:0] cnt [NUM_REGS];

  // Issuing writers reload their latency; every other busy counter drains by one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (set_en[0] && set_addr[0] == REG_ADDR_WIDTH'(i))
          cnt[i] <= set_lat[0];
        else if (set_en[1] && set_addr[1] == REG_ADDR_WIDTH'(i))
          cnt[i] <= set_lat[1];
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - LAT_WIDTH'(1);
      end
    end
  end

  // Source ports only need "ready"; rt ports need the count for WAW ordering.
  always_comb begin
    for (int k = 0; k < NUM_SRC_PORTS; k++) src_ready[k] = (cnt[src_addr[k]] == '0);
    for (int k = 0; k < 2; k++) rt_count[k] = cnt[rt_addr[k]];
  end

endmodule

// File: rtl/spu_issue_stage.sv
// rtl/spu_issue_stage.sv - SPU dual-issue stage; optional ISSUE_STATS_EN adds issue statistics
module spu_issue_stage
  import spu_issue_pkg::*;
#(
  parameter int NUM_REGS = SPU_NUM_REGS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    dec_valid,
  input  decoded_inst_t dec_inst0,
  input  decoded_inst_t dec_inst1,
  output logic          dec_ready,
  input  logic          flush,
  output logic          even_valid,
  output issue_fields_t even_inst,
  output logic          odd_valid,
  output issue_fields_t odd_inst
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0]   stat_dual,
  output logic [31:0]   stat_single,
  output logic [31:0]   stat_stall
`endif
);

  decoded_inst_t slot0, slot1;
  logic          v0, v1;
  logic          issue0, issue1, accept;
  logic          s0_even, s1_even, s0_rc, s1_rc, s1_raw_pair;

  logic [NUM_SRC_PORTS-1:0][REG_ADDR_WIDTH-1:0] src_addr;
  logic [NUM_SRC_PORTS-1:0]                     src_ready;
  logic [1:0][REG_ADDR_WIDTH-1:0]               rt_addr;
  logic [1:0][LAT_WIDTH-1:0]                    rt_count;
  logic [1:0]                                   set_en;
  logic [1:0][REG_ADDR_WIDTH-1:0]               set_addr;
  logic [1:0][LAT_WIDTH-1:0]                    set_lat;

  logic          nxt_even_valid, nxt_odd_valid;
  issue_fields_t nxt_even_inst, nxt_odd_inst;

  // The odd pipe ignores rc, so only the even slot of a pair needs an rc port.
  assign s0_even = (slot0.pipe == PIPE_EVEN);
  assign s1_even = (slot1.pipe == PIPE_EVEN);
  assign s0_rc   = slot0.uses_rc && s0_even;
  assign s1_rc   = slot1.uses_rc && s1_even;

  assign src_addr = {s0_even ? slot0.rc : slot1.rc, slot1.rb, slot1.ra, slot0.rb, slot0.ra};
  assign rt_addr  = {slot1.rt, slot0.rt};
  assign set_en   = {issue1 && slot1.wr_en, issue0 && slot0.wr_en};
  assign set_addr = {slot1.rt, slot0.rt};
  assign set_lat  = {slot1.lat, slot0.lat};

  spu_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk       (clk),
    .reset     (reset),
    .set_en    (set_en),
    .set_addr  (set_addr),
    .set_lat   (set_lat),
    .src_addr  (src_addr),
    .src_ready (src_ready),
    .rt_addr   (rt_addr),
    .rt_count  (rt_count)
  );

  // Issue decision on the buffer head; slot1 only ever issues alongside slot0.
  always_comb begin
    issue0 = v0 && !flush
          && (!slot0.uses_ra || src_ready[0])
          && (!slot0.uses_rb || src_ready[1])
          && (!s0_rc || src_ready[4])
          && (!slot0.wr_en || rt_count[0] <= slot0.lat);
    s1_raw_pair = slot0.wr_en
          && ((slot1.uses_ra && slot1.ra == slot0.rt)
           || (slot1.uses_rb && slot1.rb == slot0.rt)
           || (s1_rc && slot1.rc == slot0.rt));
    issue1 = v1 && issue0 && (slot1.pipe != slot0.pipe)
          && (!slot1.uses_ra || src_ready[2])
          && (!slot1.uses_rb || src_ready[3])
          && (!s1_rc || src_ready[4])
          && (!slot1.wr_en || rt_count[1] <= slot1.lat)
          && !s1_raw_pair
          && !(slot0.wr_en && slot1.wr_en && slot0.rt == slot1.rt);
    dec_ready = !v0 || (issue0 && (!v1 || issue1));
    accept    = dec_ready && (|dec_valid) && !flush;
  end

  // Steer issuing slots onto their pipes; idle pipes present all-zero fields.
  always_comb begin
    nxt_even_valid = 1'b0;
    nxt_odd_valid  = 1'b0;
    nxt_even_inst  = '0;
    nxt_odd_inst   = '0;
    if (issue0) begin
      if (s0_even) begin nxt_even_valid = 1'b1; nxt_even_inst = to_issue(slot0); end
      else         begin nxt_odd_valid  = 1'b1; nxt_odd_inst  = to_issue(slot0); end
    end
    if (issue1) begin
      if (s1_even) begin nxt_even_valid = 1'b1; nxt_even_inst = to_issue(slot1); end
      else         begin nxt_odd_valid  = 1'b1; nxt_odd_inst  = to_issue(slot1); end
    end
    nxt_odd_inst.rc = '0;
  end

  // Two-slot in-order buffer: load a pair, or shift a leftover slot1 to the head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0    <= 1'b0;
      v1    <= 1'b0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else if (accept) begin
      slot0 <= dec_inst0;
      slot1 <= dec_inst1;
      v0    <= dec_valid[0];
      v1    <= dec_valid[1];
    end else if (issue0 && v1 && !issue1) begin
      slot0 <= slot1;
      v1    <= 1'b0;
    end else if (issue0) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
    end
  end

  // Registered issue outputs toward the datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      even_valid <= 1'b0;
      odd_valid  <= 1'b0;
      even_inst  <= '0;
      odd_inst   <= '0;
    end else begin
      even_valid <= nxt_even_valid;
      odd_valid  <= nxt_odd_valid;
      even_inst  <= nxt_even_inst;
      odd_inst   <= nxt_odd_inst;
    end
  end

  // A lone slot1 instruction would break in-order issue.
  a_no_lone_slot1: assert property (@(posedge clk) disable iff (reset) dec_valid != 2'b10);

`ifdef ISSUE_STATS_EN
  // Saturating counters of dual issues, single issues and stalled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_dual   <= '0;
      stat_single <= '0;
      stat_stall  <= '0;
    end else begin
      if (issue1 && stat_dual != '1)               stat_dual   <= stat_dual + 32'd1;
      if (issue0 && !issue1 && stat_single != '1)  stat_single <= stat_single + 32'd1;
      if (v0 && !issue0 && stat_stall != '1)       stat_stall  <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
